beta_writeback: RTL and testbench

//  Writeback stage directly upstream of the register file.
//  - Takes one retiring instruction per handshake and selects its result: PC+4, ALU result or a memory load.
//  - Runs the load request/acknowledge handshake with data memory, with a timeout.
//  - Drives wdata / rc / werf / wasel into the register file for exactly one cycle per write.

---
 rtl/beta_writeback.sv | 139 +++++++++++++
 tb/tb_beta_writeback.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/beta_writeback.sv
// beta_writeback: writeback stage selecting PC+4 / ALU / load result for the register file
// Ports: clock, reset (synchronous, active-low)
//   valid_in/ready_out       upstream handshake, transfer on valid_in & ready_out
//   wdsel, rc, alu_result, pc_plus4  retiring instruction (wdsel 0=PC+4 1=ALU 2=load 3=none)
//   mem_req/mem_addr/mem_ack/mem_rdata  data-memory load handshake
//   wdata/rc_out/werf/wasel  register-file write (wasel selects XP = r30)
//   fault                    one-cycle pulse on load timeout
// Option: `define WB_FORWARD_EN adds byp_valid/byp_rc/byp_data, copies of the write being committed.
module beta_writeback #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [1:0]        wdsel,
  input  logic [4:0]        rc,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] pc_plus4,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] wdata,
  output logic [4:0]        rc_out,
  output logic              werf,
  output logic              wasel,
  output logic              fault
`ifdef WB_FORWARD_EN
  ,
  output logic              byp_valid,
  output logic [4:0]        byp_rc,
  output logic [DATA_W-1:0] byp_data
`endif
);
  typedef enum logic [1:0] {IDLE, WRITE, LOAD_WAIT} state_t;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, mem_addr_q, mem_addr_d, lpc_q, lpc_d;
  logic [4:0]        rc_out_q, rc_out_d, lrc_q, lrc_d;
  logic              werf_q, werf_d, wasel_q, wasel_d, mem_req_q, mem_req_d, fault_q, fault_d;
  logic [7:0]        cnt_q, cnt_d;
  always_comb begin
    state_d    = state_q;
    wdata_d    = wdata_q;
    rc_out_d   = rc_out_q;
    werf_d     = 1'b0;
    wasel_d    = wasel_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fault_d    = 1'b0;
    cnt_d      = cnt_q;
    lrc_d      = lrc_q;
    lpc_d      = lpc_q;
    if (state_q == LOAD_WAIT) begin
      // ack is checked first so an ack in the timeout cycle wins over the fault
      if (mem_ack) begin
        state_d   = WRITE;
        mem_req_d = 1'b0;
        wdata_d   = mem_rdata;
        rc_out_d  = lrc_q;
        wasel_d   = 1'b0;
        werf_d    = lrc_q != 5'd31;
      end else if (cnt_q == TO_LAST) begin
        state_d   = WRITE;
        mem_req_d = 1'b0;
        wdata_d   = lpc_q;
        rc_out_d  = lrc_q;
        wasel_d   = 1'b1;
        werf_d    = 1'b1;
        fault_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (valid_in) begin
      case (wdsel)
        2'd0, 2'd1: begin
          state_d  = WRITE;
          wdata_d  = wdsel[0] ? alu_result : pc_plus4;
          rc_out_d = rc;
          wasel_d  = 1'b0;
          werf_d   = rc != 5'd31;
        end
        2'd2: begin
          state_d    = LOAD_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = alu_result;
          lrc_d      = rc;
          lpc_d      = pc_plus4;
          cnt_d      = 8'd0;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      wdata_q    <= '0;
      rc_out_q   <= '0;
      werf_q     <= 1'b0;
      wasel_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
      lrc_q      <= '0;
      lpc_q      <= '0;
    end else begin
      state_q    <= state_d;
      wdata_q    <= wdata_d;
      rc_out_q   <= rc_out_d;
      werf_q     <= werf_d;
      wasel_q    <= wasel_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
      lrc_q      <= lrc_d;
      lpc_q      <= lpc_d;
    end
  end
  assign ready_out = state_q != LOAD_WAIT;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign wdata     = wdata_q;
  assign rc_out    = rc_out_q;
  assign werf      = werf_q;
  assign wasel     = wasel_q;
  assign fault     = fault_q;
`ifdef WB_FORWARD_EN
  assign byp_valid = werf_q;
  assign byp_rc    = wasel_q ? 5'd30 : rc_out_q;
  assign byp_data  = wdata_q;
`endif
endmodule

// File: tb/tb_beta_writeback.sv
// tb_beta_writeback: randomized scoreboard bench for beta_writeback
module tb_beta_writeback;
  localparam int TO = 15;
  logic        clock = 1'b0, reset = 1'b0, valid_in = 1'b0, mem_ack = 1'b0;
  logic [1:0]  wdsel = '0;
  logic [4:0]  rc = '0;
  logic [31:0] alu_result = '0, pc_plus4 = '0, mem_rdata = '0;
  logic        ready_out, mem_req, werf, wasel, fault;
  logic [31:0] mem_addr, wdata;
  logic [4:0]  rc_out;
  typedef struct {logic [31:0] data; logic [4:0] rc; logic wasel; logic fault; int cyc;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;

  beta_writeback #(.DATA_W(32), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .wdsel(wdsel), .rc(rc), .alu_result(alu_result), .pc_plus4(pc_plus4),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wdata(wdata), .rc_out(rc_out), .werf(werf), .wasel(wasel), .fault(fault)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // monitor: every write/fault pulse must match the oldest expected write
  always @(negedge clock) begin
    if (werf === 1'b1 || fault === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual werf=%b fault=%b wdata=%h required no write", werf, fault, wdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("werf", werf, 1);
        chk("wdata", wdata, e.data);
        chk("wasel", wasel, e.wasel);
        chk("fault", fault, e.fault);
        if (!e.wasel) chk("rc_out", rc_out, e.rc);
      end
    end
  end

  // lat: load ack arrives in wait cycle lat (1..TO); lat > TO means no ack -> timeout
  task automatic issue(input logic [1:0] ws, input logic [4:0] r, input logic [31:0] alu,
                       input logic [31:0] pc, input int lat, input logic [31:0] rd);
    exp_t e;
    int n;
    valid_in = 1'b1; wdsel = ws; rc = r; alu_result = alu; pc_plus4 = pc;
    if (ws == 2'd2) begin
      n = (lat <= TO) ? lat : TO;
      e.rc = r;
      e.cyc = cyc + 1 + n;
      e.data = (lat <= TO) ? rd : pc;
      e.wasel = lat > TO;
      e.fault = lat > TO;
      if (lat > TO || r != 5'd31) q.push_back(e);
      step();
      for (int k = 1; k <= n; k++) begin
        chk("mem_req", mem_req, 1);
        chk("mem_addr", mem_addr, alu);
        chk("ready_wait", ready_out, 0);
        mem_ack = (k == lat);
        mem_rdata = (k == lat) ? rd : $urandom;
        valid_in = 1'($urandom); wdsel = 2'($urandom); rc = 5'($urandom);
        alu_result = $urandom; pc_plus4 = $urandom;
        step();
      end
      mem_ack = 1'b0;
      valid_in = 1'b0;
      chk("mem_req_drop", mem_req, 0);
      chk("ready_after", ready_out, 1);
    end else begin
      e.data = ws[0] ? alu : pc;
      e.rc = r;
      e.wasel = 1'b0;
      e.fault = 1'b0;
      e.cyc = cyc + 1;
      if (ws != 2'd3 && r != 5'd31) q.push_back(e);
      step();
      valid_in = 1'b0;
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_werf", werf, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_rc_out", rc_out, 0);
    chk("rst_wasel", wasel, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ready", ready_out, 1);
    reset = 1'b1;
    step();
    issue(2'd1, 5'd3, 32'h11, 32'h4, 0, 0);
    issue(2'd1, 5'd4, 32'h22, 32'h8, 0, 0);
    issue(2'd0, 5'd9, 32'h33, 32'h1C, 0, 0);
    step();
    issue(2'd2, 5'd5, 32'h100, 32'h20, 3, 32'hCAFE);
    issue(2'd2, 5'd7, 32'h200, 32'h40, 99, 0);
    issue(2'd1, 5'd31, 32'h55, 32'h0, 0, 0);
    issue(2'd3, 5'd8, 32'h66, 32'h0, 0, 0);
    issue(2'd2, 5'd6, 32'h300, 32'h44, TO, 32'hBEEF);
    issue(2'd2, 5'd10, 32'h400, 32'h48, 1, 32'h1234);
    for (int i = 0; i < 300; i++) begin
      int ws;
      ws = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        valid_in = 1'b0;
        alu_result = $urandom;
        step();
      end
      issue(2'(ws), 5'($urandom), $urandom, $urandom, $urandom_range(1, TO + 3), $urandom);
    end
    step();
    valid_in = 1'b1; wdsel = 2'd2; rc = 5'd9; alu_result = 32'h500; pc_plus4 = 32'h60;
    step();
    valid_in = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD;
    chk("rst_load_mem_req", mem_req, 0);
    chk("rst_load_ready", ready_out, 1);
    chk("rst_load_werf", werf, 0);
    step();
    mem_ack = 1'b0;
    chk("ack_ignored_werf", werf, 0);
    chk("ack_ignored_mem_req", mem_req, 0);
    repeat (4) step();
    chk("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
